// File: rtl/fpcvt_pkg.sv
// Shared widths and FSM state type for the fixed-point to mini-float scheduler.
package fpcvt_pkg;

  localparam int IN_W  = 12;
  localparam int MAG_W = 11;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fpcvt_conv.sv
// Convert unit: 11-bit magnitude -> 3-bit exponent and 4-bit truncated significand.
// The exponent is the position of the leading one minus 3, floored at 0,
// so the significand window always holds the top four significant bits.
module fpcvt_conv
  import fpcvt_pkg::*;
(
  input  logic [MAG_W-1:0] mag,
  output logic [EXP_W-1:0] e,
  output logic [SIG_W-1:0] f
);

  // Leading-one search; the highest set bit at or above bit 3 wins.
  always_comb begin
    e = '0;
    for (int b = SIG_W - 1; b < MAG_W; b++) begin
      if (mag[b]) e = EXP_W'(b - (SIG_W - 1));
    end
    f = mag[e +: SIG_W];
  end

endmodule

// File: rtl/fpcvt_sched.sv
// Round-robin scheduler sharing one fixed-to-float converter among NREQ requesters.
// Handshake: a transfer happens on any cycle where valid && ready are both high;
// the producer may change data only after such a cycle, the consumer samples then.
module fpcvt_sched
  import fpcvt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*IN_W-1:0]   req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ID_W-1:0]        out_id,
  output logic                   out_s,
  output logic [EXP_W-1:0]       out_e,
  output logic [SIG_W-1:0]       out_f,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   idx;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic [NREQ-1:0]   grant;
  logic [IN_W-1:0]   win_data;
  logic [MAG_W-1:0]  win_neg;
  logic [MAG_W-1:0]  win_mag;
  logic              win_s;
  logic [MAG_W-1:0]  mag_q;
  logic              s_q;
  logic [ID_W-1:0]   id_q;
  logic [EXP_W-1:0]  ce;
  logic [SIG_W-1:0]  cf;
  logic              rbit;
  logic [SIG_W:0]    fsum;
  logic [EXP_W-1:0]  re;
  logic [SIG_W-1:0]  rf;

  // Round-robin search starting at ptr; index wraps because NREQ is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + ID_W'(k);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // One-hot grant, only offered while idle and never during reset.
  always_comb begin
    grant = '0;
    if (state == IDLE && win_found && !rst) grant[win_id] = 1'b1;
  end

  assign req_ready = grant;

  // Sign/magnitude of the winner; -2048 has no 11-bit magnitude and saturates.
  always_comb begin
    win_data = req_data[int'(win_id) * IN_W +: IN_W];
    win_s    = win_data[IN_W-1];
    win_neg  = ~win_data[MAG_W-1:0] + MAG_W'(1);
    if (win_data == {1'b1, {(IN_W-1){1'b0}}}) win_mag = '1;
    else if (win_s)                           win_mag = win_neg;
    else                                      win_mag = win_data[MAG_W-1:0];
  end

  fpcvt_conv u_conv (
    .mag (mag_q),
    .e   (ce),
    .f   (cf)
  );

  // Round half up on the first dropped bit; a carry out renormalises or saturates.
  always_comb begin
    rbit = (ce != '0) ? mag_q[ce - EXP_W'(1)] : 1'b0;
    fsum = {1'b0, cf} + {{SIG_W{1'b0}}, rbit};
    if (fsum[SIG_W]) begin
      if (ce == '1) begin
        re = '1;
        rf = '1;
      end else begin
        re = ce + EXP_W'(1);
        rf = {1'b1, {(SIG_W-1){1'b0}}};
      end
    end else begin
      re = ce;
      rf = fsum[SIG_W-1:0];
    end
  end

  // Control FSM: accept in IDLE, register result in CONV, hold it in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= '0;
      out_f     <= '0;
      out_id    <= '0;
      mag_q     <= '0;
      s_q       <= 1'b0;
      id_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            mag_q <= win_mag;
            s_q   <= win_s;
            id_q  <= win_id;
            ptr   <= win_id + ID_W'(1);
            state <= CONV;
          end
        end
        CONV: begin
          out_s     <= s_q;
          out_e     <= re;
          out_f     <= rf;
          out_id    <= id_q;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_fpcvt_sched.sv
// Bench for fpcvt_sched: directed scenarios plus randomized traffic against a
// transaction-level reference model evaluated on every falling edge.
module tb_fpcvt_sched;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*12-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [ID_W-1:0]      out_id;
  logic                 out_s;
  logic [2:0]           out_e;
  logic [3:0]           out_f;
  logic                 busy;
  logic [1:0]           dbg_state;

  int checks = 0;
  int errors = 0;

  // model state: 0 = free, 1 = converting, 2 = result held
  int phase = 0;
  int ptr_m = 0;
  logic [ID_W+7:0] exp_q[$];
  int gnt_log[$];

  fpcvt_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference conversion from plain arithmetic: {s, e, f}.
  function automatic logic [7:0] conv_model(input logic [11:0] d);
    int v, m, p, e, f;
    logic s;
    v = int'($signed(d));
    s = (v < 0);
    m = s ? -v : v;
    if (m > 2047) m = 2047;
    p = -1;
    for (int b = 0; b < 11; b++) if (m >= (1 << b)) p = b;
    e = (p > 3) ? p - 3 : 0;
    f = (e > 0) ? ((m + (1 << (e - 1))) >> e) : m;
    if (f == 16) begin
      if (e == 7) f = 15;
      else begin e = e + 1; f = 8; end
    end
    return {s, 3'(e), 4'(f)};
  endfunction

  // Compare process: checks DUT against the model, then advances the model.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    int win, idx;
    if (rst) begin
      phase = 0;
      ptr_m = 0;
      exp_q.delete();
    end else begin
      exp_rdy = '0;
      win = -1;
      if (phase == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (ptr_m + k) % NREQ;
          if (win < 0 && req_valid[idx]) win = idx;
        end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(phase == 2));
      check("busy", 32'(busy), 32'(phase != 0));
      if (phase == 2 && exp_q.size() > 0)
        check("result", 32'({out_id, out_s, out_e, out_f}), 32'(exp_q[0]));
      for (int k = 0; k < NREQ; k++) if (req_ready[k]) gnt_log.push_back(k);
      case (phase)
        0: if (win >= 0) begin
             exp_q.push_back({ID_W'(win), conv_model(req_data[12*win +: 12])});
             ptr_m = (win + 1) % NREQ;
             phase = 1;
           end
        1: phase = 2;
        default: if (out_ready) begin
             if (exp_q.size() > 0) void'(exp_q.pop_front());
             phase = 0;
           end
      endcase
    end
  end

  // driver: single requester, waits for grant and checks the result 2 cycles later
  task automatic send(input int i, input logic [11:0] d, input int es, input int ee, input int ef);
    bit got;
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[i] = 1'b1;
    req_data[12*i +: 12] = d;
    out_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1;
    end
    check("grant_wait", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    @(negedge clk);
    check("lat_conv_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_done_valid", 32'(out_valid), 32'd1);
    check("lit_result", 32'({out_id, out_s, out_e, out_f}),
          32'({ID_W'(i), 1'(es), 3'(ee), 4'(ef)}));
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 10 && busy; t++) @(negedge clk);
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $finish;
  end

  initial begin : main
    bit got;
    int exp_ord[5];
    logic [11:0] specials[6];
    exp_ord  = '{0, 1, 2, 3, 0};
    specials = '{12'h000, 12'h7FF, 12'h800, 12'h801, 12'h07D, 12'hFFF};

    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_fields", 32'({out_id, out_s, out_e, out_f}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // model pins
    check("model_422", 32'(conv_model(12'd422)), 32'({1'b0, 3'd5, 4'd13}));
    check("model_7", 32'(conv_model(12'd7)), 32'({1'b0, 3'd0, 4'd7}));
    check("model_125", 32'(conv_model(12'd125)), 32'({1'b0, 3'd4, 4'd8}));
    check("model_2047", 32'(conv_model(12'd2047)), 32'({1'b0, 3'd7, 4'd15}));
    check("model_m2048", 32'(conv_model(12'h800)), 32'({1'b1, 3'd7, 4'd15}));
    check("model_zero", 32'(conv_model(12'd0)), 32'd0);

    // directed conversions
    send(0, 12'd422, 0, 5, 13);
    send(1, 12'd7, 0, 0, 7);
    send(1, 12'd125, 0, 4, 8);
    send(0, 12'd2047, 0, 7, 15);
    send(3, 12'h800, 1, 7, 15);
    send(2, 12'd0, 0, 0, 0);
    send(1, 12'hF5C, 1, 4, 10);   // -164: 164/16 = 10.25 -> 10

    // backpressure: result held, no new grant while stalled
    @(posedge clk); #1;
    out_ready = 1'b0;
    req_valid = '0;
    req_valid[2] = 1'b1;
    req_data[24 +: 12] = 12'd100;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (req_ready[2]) got = 1;
    end
    check("bp_grant_wait", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    req_valid[3] = 1'b1;
    req_data[36 +: 12] = 12'd5;
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_no_grant", 32'(req_ready), 32'd0);
      check("bp_hold", 32'({out_id, out_s, out_e, out_f}), 32'({2'd2, 1'b0, 3'd3, 4'd13}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("bp_next_grant", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // reset while converting
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    req_data[12 +: 12] = 12'd422;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (req_ready[1]) got = 1;
    end
    check("abort_grant_wait", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    check("abort_valid2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    check("abort_ptr_zero", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // all requesters from reset: round-robin order
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '1;
    out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) req_data[12*i +: 12] = 12'(100 * (i + 1));
    @(posedge clk); #1;
    rst = 1'b0;
    gnt_log.delete();
    repeat (15) @(negedge clk);
    check("rr_count", 32'(gnt_log.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++)
      if (k < gnt_log.size()) check("rr_order", 32'(gnt_log[k]), 32'(exp_ord[k]));

    // randomized traffic
    repeat (600) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 79) == 0);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        req_data[12*i +: 12] = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)]
                                                           : 12'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end

    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpcvt_sched.md
FPCVT_SCHED -- requirements
Module: fpcvt_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing the converter (power of two, 2..8).
REQ-002 The block SHALL have derived parameter ID_W, default $clog2(NREQ), the requester-index width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester request strobe.
REQ-006 The block SHALL have port req_data  input  NREQ*12  per-requester 12-bit two's-complement sample; slice i at [12*i+11:12*i].
REQ-007 The block SHALL have port req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
REQ-008 The block SHALL have port out_valid  output  1  result available.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 The block SHALL have port out_id  output  ID_W  index of requester owning the result.
REQ-011 The block SHALL have ports out_s (1), out_e (3) and out_f (4), all outputs: sign, exponent, significand; value = (-1)^s * f * 2^e.
REQ-012 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL implement FSM states IDLE, CONV and DONE.
REQ-014 In IDLE, when any req_valid bit is high, the block SHALL assert req_ready for exactly one round-robin winner that same cycle, latch its data and index, and go to CONV; otherwise it SHALL stay in IDLE.
REQ-015 Round-robin: the search SHALL start at ptr, ptr+1, ... (mod NREQ); after a grant to i, ptr SHALL become (i+1) mod NREQ; ptr SHALL be unchanged when nothing is granted.
REQ-016 req_ready SHALL be all-zero in CONV and DONE.
REQ-017 In CONV the block SHALL compute and register out_s/out_e/out_f/out_id, then go to DONE unconditionally (one cycle).
REQ-018 In DONE out_valid SHALL be 1 and the outputs SHALL be held stable; on out_ready the block SHALL go to IDLE. Latency: accept at cycle N gives out_valid at N+2; peak throughput is one result per 3 cycles.
REQ-019 Sign: s = data[11]; magnitude = |data| on 11 bits; data = -2048 (0x800) SHALL saturate the magnitude to 2047.
REQ-020 Exponent: with lz = leading zeros of the 11-bit magnitude, e = 7-lz for lz<=7 and e = 0 otherwise; f = mag[e+3:e].
REQ-021 Rounding: for e>0, round bit r = mag[e-1] and f = f + r; for e=0 there is no rounding.
REQ-022 If rounding yields f = 16, the block SHALL set f = 8 and e = e+1; if e was already 7, it SHALL saturate to e = 7, f = 15.
REQ-023 Zero input SHALL give s=0, e=0, f=0.

Reset
REQ-024 On rst, the block SHALL go to IDLE with ptr=0, out_valid=0, req_ready=0, busy=0, out_s=0, out_e=0, out_f=0 and out_id=0.
REQ-025 A rst during CONV or DONE SHALL discard the in-flight result with no out_valid pulse, and the request SHALL NOT be re-granted automatically.
REQ-026 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-027 Shared package fpcvt_pkg SHALL hold IN_W=12, MAG_W=11, EXP_W=3, SIG_W=4 and the FSM state enum.
REQ-028 The block SHALL instantiate the existing convert unit (11-bit magnitude -> 3-bit exponent and 4-bit truncated significand) exactly once as its sub-module; the abs/saturation logic, rounding, arbiter and FSM SHALL live in fpcvt_sched.

Verification
REQ-029 Requester 0 sends 422 (0x1A6) -> out_s=0, out_e=5, out_f=13, out_id=0, out_valid 2 cycles after the grant.
REQ-030 Requester 1 sends 7, then 125 -> e=0,f=7, then e=4,f=8 (rounding carry).
REQ-031 Inputs 2047 and 0x800 (-2048) -> s=0,e=7,f=15 and s=1,e=7,f=15 (saturation); input 0 -> all zero.
REQ-032 All four req_valid held high from reset with out_ready=1 -> grants in order 0,1,2,3,0, each req_ready a one-cycle pulse.
REQ-033 out_ready held low for 5 cycles in DONE -> outputs stable, no new grant; grant follows the cycle after out_ready rises.
REQ-034 rst asserted in CONV -> next cycle IDLE, out_valid=0, ptr=0; no result emitted for the aborted request.
